// File: rtl/frame_buffer_ctrl.sv
// Single-port pixel frame buffer with load/scan sequencers and a 2-entry output skid buffer.
// Define FRAME_BUF_OUTREG_EN to add a RAM output register stage (read latency 2).
module frame_buffer_ctrl #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DEPTH  = 19040
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              ena,
  input  logic              ld_start,
  input  logic              rd_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StScan} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_all_q, rd_all_d;
  logic              done_q, done_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] skid_data_q [2];
  logic [1:0]        skid_last_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we, issue, pop, push, push_last, inflight, at_last;
  logic [DATA_W-1:0] push_data;
  logic [2:0]        occ;

  assign at_last   = (addr_q == LastAddr);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign in_ready  = ena && (state_q == StLoad);
  assign out_valid = ena && (cnt_q != 2'd0);
  assign out_data  = skid_data_q[rd_ptr_q];
  assign out_last  = skid_last_q[rd_ptr_q] && (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign mem_we    = in_ready && in_valid;

  // Room check counts buffered entries plus reads still in the RAM pipeline, net of this pop.
  assign occ   = {1'b0, cnt_q} + {2'b00, inflight};
  assign issue = (state_q == StScan) && !rd_all_q && (occ < (3'd2 + {2'b00, pop}));

`ifdef FRAME_BUF_OUTREG_EN
  logic              oreg_vld_q, oreg_vld_d;
  logic              oreg_last_q, oreg_last_d;
  logic [DATA_W-1:0] oreg_data_q;

  assign oreg_vld_d  = issue;
  assign oreg_last_d = issue && at_last;
  assign inflight    = oreg_vld_q;
  assign push        = oreg_vld_q;
  assign push_data   = oreg_data_q;
  assign push_last   = oreg_last_q;

  always_ff @(posedge clka) begin
    if (rsta) begin
      oreg_vld_q  <= 1'b0;
      oreg_last_q <= 1'b0;
    end else if (ena) begin
      oreg_vld_q  <= oreg_vld_d;
      oreg_last_q <= oreg_last_d;
    end
  end

  always_ff @(posedge clka) begin
    if (ena && issue) oreg_data_q <= mem[addr_q];
  end
`else
  // The skid-buffer write is the RAM read register, giving one cycle of read latency.
  assign inflight  = 1'b0;
  assign push      = issue;
  assign push_data = mem[addr_q];
  assign push_last = at_last;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_all_d = rd_all_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_start) begin
          state_d = StLoad;
          addr_d  = '0;
        end else if (rd_start) begin
          state_d  = StScan;
          addr_d   = '0;
          rd_all_d = 1'b0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          if (at_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StScan: begin
        if (issue) begin
          if (at_last) rd_all_d = 1'b1;
          else         addr_d   = addr_q + 1'b1;
        end
        if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rd_all_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_all_q <= rd_all_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      skid_data_q[0] <= '0;
      skid_data_q[1] <= '0;
      skid_last_q    <= 2'b00;
    end else if (ena && push) begin
      skid_data_q[wr_ptr_q] <= push_data;
      skid_last_q[wr_ptr_q] <= push_last;
    end
  end

  always_ff @(posedge clka) begin
    if (!rsta && mem_we) mem[addr_q] <= in_data;
  end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Self-checking bench for frame_buffer_ctrl: transaction-level model plus directed and random phases.
module tb_frame_buffer_ctrl;
  localparam int DW    = 24;
  localparam int DEPTH = 8;
`ifdef FRAME_BUF_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int MIdle = 0;
  localparam int MLoad = 1;
  localparam int MScan = 2;

  logic          clk = 1'b0;
  logic          rsta = 1'b1, ena = 1'b1, ld_start = 1'b0, rd_start = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_last, busy, done;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  frame_buffer_ctrl #(.DATA_W(DW), .ADDR_W(3), .DEPTH(DEPTH)) dut (
    .clka     (clk),
    .rsta     (rsta),
    .ena      (ena),
    .ld_start (ld_start),
    .rd_start (rd_start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: mode, frame contents, next expected pixel, enabled cycles in scan.
  int            mode = MIdle;
  int            ld_idx = 0, sc_idx = 0, age = 0;
  bit            done_m = 1'b0, model_ok = 1'b0;
  logic [DW-1:0] mem_m [DEPTH];

  always @(negedge clk) begin
    logic exp_valid;
    exp_valid = ena && (mode == MScan) && (age >= LAT);
    if (model_ok) begin
      chk("busy", busy, mode != MIdle);
      chk("done", done, done_m);
      chk("in_ready", in_ready, ena && (mode == MLoad));
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("out_data", out_data, mem_m[sc_idx]);
        chk("out_last", out_last, sc_idx == DEPTH - 1);
      end
    end
    if (rsta) begin
      mode     = MIdle;
      done_m   = 1'b0;
      model_ok = 1'b1;
    end else if (ena && model_ok) begin
      done_m = 1'b0;
      case (mode)
        MIdle: begin
          if (ld_start) begin
            mode   = MLoad;
            ld_idx = 0;
          end else if (rd_start) begin
            mode   = MScan;
            sc_idx = 0;
            age    = 0;
          end
        end
        MLoad: begin
          if (in_valid) begin
            mem_m[ld_idx] = in_data;
            if (ld_idx == DEPTH - 1) begin
              mode   = MIdle;
              done_m = 1'b1;
            end else ld_idx++;
          end
        end
        default: begin
          if (exp_valid && out_ready) begin
            if (sc_idx == DEPTH - 1) begin
              mode   = MIdle;
              done_m = 1'b1;
            end else sc_idx++;
          end
          age++;
        end
      endcase
    end
  end

  logic [DW-1:0] hs_q [$];
  bit            lq [$];
  int            first_v, first_hs, last_hs, done_cyc;

  // Starts a scan and records handshakes; stops on done or after stop_n handshakes.
  task automatic scan_collect(input bit bp, input int stop_n);
    bit fin;
    fin = 1'b0;
    hs_q.delete();
    lq.delete();
    first_v  = -1;
    first_hs = -1;
    last_hs  = -1;
    done_cyc = -1;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      out_ready = bp ? (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (out_valid && first_v < 0) first_v = k;
      if (out_valid && out_ready) begin
        hs_q.push_back(out_data);
        lq.push_back(out_last);
        if (first_hs < 0) first_hs = k;
        last_hs = k;
      end
      if (done) begin
        done_cyc = k;
        fin = 1'b1;
      end
      if (stop_n > 0 && hs_q.size() == stop_n) fin = 1'b1;
      step();
      if (fin) break;
    end
    chk("scan_timeout", fin, 1'b1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_count"}, hs_q.size(), DEPTH);
    for (int i = 0; i < hs_q.size() && i < DEPTH; i++) begin
      chk({tag, "_data"}, hs_q[i], 32'(i + 1));
      chk({tag, "_last"}, lq[i], i == DEPTH - 1);
    end
  endtask

  task automatic wait_done();
    bit fin;
    fin = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) fin = 1'b1;
      step();
      if (fin) break;
    end
    chk("done_timeout", fin, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_rdy;
    repeat (2) step();
    rsta = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    step();

    // Simultaneous starts: load must win; a later rd_start during LOAD is ignored.
    ld_start = 1'b1;
    rd_start = 1'b1;
    step();
    ld_start = 1'b0;
    in_valid = 1'b1;
    n_rdy    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DW'(i + 1);
      @(negedge clk);
      if (i == 0) chk("arb_in_ready", in_ready, 1);
      if (in_ready) n_rdy++;
      step();
      rd_start = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("ld_ready_cycles", n_rdy, DEPTH);
    chk("ld_done", done, 1);
    chk("ld_busy_low", busy, 0);
    step();

    scan_collect(1'b0, 0);
    chk("latency_first_valid", first_v, LAT + 1);
    check_frame("full");
    chk("full_no_bubble", last_hs - first_hs, DEPTH - 1);
    chk("full_done_cycle", done_cyc, last_hs + 1);

    scan_collect(1'b1, 0);
    check_frame("bp");
    chk("bp_done_cycle", done_cyc, last_hs + 1);

    // Hold pixel 3, freeze for 5 cycles, then expect 3 re-presented followed by 4.
    scan_collect(1'b0, 2);
    out_ready = 1'b0;
    @(negedge clk);
    chk("frz_hold_valid", out_valid, 1);
    chk("frz_hold_data", out_data, 3);
    step();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("frz_valid_low", out_valid, 0);
      step();
    end
    ena = 1'b1;
    @(negedge clk);
    chk("frz_resume_valid", out_valid, 1);
    chk("frz_resume_data", out_data, 3);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("frz_again_data", out_data, 3);
    step();
    @(negedge clk);
    chk("frz_next_data", out_data, 4);
    step();
    wait_done();

    // Reset after 3 pixels, then a fresh scan must return the retained frame.
    scan_collect(1'b0, 3);
    rsta = 1'b1;
    step();
    rsta = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    step();
    scan_collect(1'b0, 0);
    check_frame("post_rst");

    for (int c = 0; c < 4000; c++) begin
      rsta      = ($urandom_range(0, 299) == 0);
      ena       = ($urandom_range(0, 7) != 0);
      ld_start  = ($urandom_range(0, 40) == 0);
      rd_start  = ($urandom_range(0, 25) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    ena       = 1'b1;
    ld_start  = 1'b0;
    rd_start  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rsta      = 1'b1;
    step();
    rsta = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
